// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLDING,
        SAMPLE,
        FINISH
    } tt_state_t;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/hold_counter.sv
// Settle-delay counter: synchronous clear, increment enable, terminal flag at HOLD-1.
module hold_counter
    import tt_sweep_pkg::*;
#(
    parameter int unsigned HOLD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [HOLD_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign term = (r_cnt == HOLD_W'(HOLD - 1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps an external N-input function through all codes, captures its truth table
// and compares it against a golden mask captured at start.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      vec,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_err
);

    localparam logic [N_IN-1:0] LAST_CODE = '1;

    tt_state_t          r_state;
    tt_state_t          w_next;
    logic [N_IN-1:0]    r_vec;
    logic [2**N_IN-1:0] r_exp;
    logic [2**N_IN-1:0] r_table;
    logic               r_mismatch;
    logic [N_IN-1:0]    r_first_err;

    logic w_accept;
    logic w_last;
    logic w_hold_term;
    logic w_hold_clr;
    logic w_hold_inc;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_last     = (r_vec == LAST_CODE);
    assign w_hold_clr = w_accept || ((r_state == SAMPLE) && !w_last);
    assign w_hold_inc = (r_state == HOLDING);

    hold_counter #(
        .HOLD(HOLD)
    ) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_hold_clr),
        .inc  (w_hold_inc),
        .term (w_hold_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = HOLDING;
            HOLDING: if (w_hold_term) w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? FINISH : HOLDING;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Codes are visited in ascending order, so the first flagged error is the lowest code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= '0;
            r_exp       <= '0;
            r_table     <= '0;
            r_mismatch  <= 1'b0;
            r_first_err <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_exp       <= expected;
                        r_vec       <= '0;
                        r_table     <= '0;
                        r_mismatch  <= 1'b0;
                        r_first_err <= '0;
                    end
                end
                SAMPLE: begin
                    r_table[r_vec] <= f_in;
                    if ((f_in != r_exp[r_vec]) && !r_mismatch) begin
                        r_mismatch  <= 1'b1;
                        r_first_err <= r_vec;
                    end
                    if (!w_last) begin
                        r_vec <= r_vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec       = r_vec;
    assign busy      = (r_state == HOLDING) || (r_state == SAMPLE);
    assign done      = (r_state == FINISH);
    assign table_out = r_table;
    assign mismatch  = r_mismatch;
    assign first_err = r_first_err;

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencing controller that drives an external combinational N-input function block (e.g. the 4-input `f3` logic) through all 2^N input codes in ascending order. It captures the function output per code into a truth-table register and compares the result against an expected mask. It sits between a host/test harness (start/done handshake) and the function block (drives its input vector, samples its output), replacing hand-written stimulus loops with a reusable hardware sweeper.

## Interface
Parameters:
- `N_IN`, 4: width of the function input vector; table width is `2**N_IN`.
- `HOLD`, 2: cycles each input code is held before its output is sampled; legal range 1..255.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: sweep request; sampled only in IDLE.
- `expected`  in  2^N_IN: golden truth table, bit k = expected output for code k; captured on accepted start.
- `vec`  out  N_IN: input code driven to the function block, bit order {a,b,c,d} MSB-first for N_IN=4.
- `f_in`  in  1: function block output.
- `busy`  out  1: high from the cycle after accepted start through the last sample cycle.
- `done`  out  1: one-cycle pulse after the sweep completes.
- `table_out`  out  2^N_IN: captured truth table, bit k = sampled `f_in` for code k.
- `mismatch`  out  1: valid with `done`, held until next accepted start; 1 if `table_out != expected_q`.
- `first_err`  out  N_IN: lowest code whose bit mismatched; 0 when `mismatch`=0.

## Operation
- FSM states: IDLE, HOLDING, SAMPLE, FINISH.
- IDLE: `start`=1 → `expected_q`<=`expected`, `vec`<=0, hold counter<=0, `table_out`<=0, `mismatch`<=0, `first_err`<=0, go HOLDING.
- HOLDING: counter increments each cycle; when counter == HOLD-1, go SAMPLE. With HOLD=1, HOLDING lasts one cycle.
- SAMPLE: `table_out[vec]`<=`f_in`. If `f_in != expected_q[vec]` and no earlier error, `first_err`<=`vec` and `mismatch`<=1.
  - If `vec` == 2^N_IN-1, go FINISH.
  - Otherwise `vec`<=`vec`+1, counter<=0, go HOLDING.
- FINISH: `done`=1 for exactly this cycle, then IDLE. `vec` stays at 2^N_IN-1.
- `start` while not in IDLE is ignored, with no queuing. `start` held high in IDLE immediately after FINISH begins a new sweep.
- `vec` increments without modular wrap; the terminal test happens before increment.
- Reset, asynchronous and usable mid-sweep: FSM→IDLE, `vec`=0, `busy`=0, `done`=0, `table_out`=0, `mismatch`=0, `first_err`=0, counter=0. A partial table is discarded.

## Timing
- All outputs are registered; `busy` is decoded from state (HOLDING|SAMPLE), registered-equivalent.
- Accepted start at edge t0: `vec`=0 visible after t0.
- Each code occupies HOLD+1 cycles: HOLD cycles settling, then 1 SAMPLE cycle. `f_in` is sampled on the edge leaving SAMPLE, so the function has ≥HOLD+1 cycles of settle time.
- Sweep length from accepted start to `done` high: 2^N_IN·(HOLD+1) cycles. For N_IN=4, HOLD=2 that is 48 cycles; `done` is asserted in cycle 49.
- `table_out`, `mismatch` and `first_err` are final and stable when `done`=1, and held until the next accepted start.

## Structure
- Shared package `tt_sweep_pkg`:
  - state enum `tt_state_t` {IDLE, HOLDING, SAMPLE, FINISH};
  - `HOLD_W`=8 localparam for the counter width.
- Single module plus one natural sub-module `hold_counter` (load/clear, increment, terminal flag at HOLD-1), reusable for other settle-delay sequencers.
- The function block is instantiated beside the controller in the top/bench, not inside it.

## Test plan
- Golden f3 (=~c~d | b·d), N_IN=4, HOLD=2, `expected`=16'hB1B1, pulse `start` → `vec` steps 0..15 every 3 cycles, `done` at cycle 49, `table_out`=16'hB1B1, `mismatch`=0, `first_err`=0.
- Same DUT, `expected`=16'hB1B3 → `table_out`=16'hB1B1, `mismatch`=1, `first_err`=1. With `expected`=16'h31B1 → `first_err`=15.
- HOLD=1, `f_in` tied 1, `expected`=16'hFFFF → sweep takes 32 cycles, `table_out`=16'hFFFF, `done` exactly 1 cycle wide.
- `start` pulsed at cycle 10 of a sweep → ignored: `vec` sequence, `done` time and results identical to the clean run; `start` held high continuously → back-to-back sweeps, IDLE lasting one cycle between them.
- `rst_n` low asynchronously while `vec`=7 (mid-HOLDING) → immediately `busy`=0, `vec`=0, `table_out`=0, no `done`. A subsequent `start` produces a full correct sweep (16'hB1B1).
